// File: rtl/div_pkg.sv
// div_pkg: shared FSM state encoding for the sequential restoring divider.
package div_pkg;
   typedef enum logic [1:0] {IDLE, OP, DONE} state_t;
endpackage

// File: rtl/sub_borrow_para.sv
// sub_borrow_para: N-bit unsigned subtractor with borrow out.
module sub_borrow_para #(parameter int N = 8) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] diff,
   output logic         bout
);
   assign {bout, diff} = {1'b0, a} - {1'b0, b};
endmodule

// File: rtl/div_seq_para.sv
// div_seq_para: sequential restoring divider, one quotient bit per cycle.
// DIV_ZERO_CHK_EN: a zero divisor skips OP and flags div0.
module div_seq_para
   import div_pkg::*;
#(parameter int N = 8) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [N-1:0] dvnd,
   input  logic [N-1:0] dvsr,
   output logic         ready,
   output logic         done_tick,
   output logic [N-1:0] quo,
   output logic [N-1:0] rmd,
   output logic         div0
);
   localparam int CW = $clog2(N + 1);
   state_t        state;
   logic [CW-1:0] cnt;
   logic [N-1:0]  rem, q, d, rem_nx, q_nx;
   logic [N:0]    rem_sh, diff;
   logic          bout, unused_msb;
   assign rem_sh = {rem, q[N-1]};
   sub_borrow_para #(.N(N + 1)) u_sub (
      .a(rem_sh), .b({1'b0, d}), .diff(diff), .bout(bout)
   );
   // on success the difference is below the divisor, so its top bit is always zero
   assign rem_nx     = bout ? rem_sh[N-1:0] : diff[N-1:0];
   assign q_nx       = {q[N-2:0], ~bout};
   assign unused_msb = diff[N];
`ifndef DIV_ZERO_CHK_EN
   assign div0 = 1'b0;
`endif
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         rem       <= '0;
         q         <= '0;
         d         <= '0;
         quo       <= '0;
         rmd       <= '0;
         done_tick <= 1'b0;
         ready     <= 1'b1;
`ifdef DIV_ZERO_CHK_EN
         div0      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (start) begin
               q     <= dvnd;
               d     <= dvsr;
               rem   <= '0;
               cnt   <= CW'(N);
               ready <= 1'b0;
`ifdef DIV_ZERO_CHK_EN
               if (dvsr == '0) begin
                  state     <= DONE;
                  quo       <= '1;
                  rmd       <= dvnd;
                  div0      <= 1'b1;
                  done_tick <= 1'b1;
               end else state <= OP;
`else
               state <= OP;
`endif
            end
            OP: begin
               rem <= rem_nx;
               q   <= q_nx;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state     <= DONE;
                  quo       <= q_nx;
                  rmd       <= rem_nx;
                  done_tick <= 1'b1;
`ifdef DIV_ZERO_CHK_EN
                  div0      <= 1'b0;
`endif
               end
            end
            DONE: begin
               state     <= IDLE;
               done_tick <= 1'b0;
               ready     <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_div_seq_para.sv
// tb_div_seq_para: scoreboard bench for div_seq_para with N=8.
module tb_div_seq_para;
   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       d;
      int         c;
   } exp_t;
`ifdef DIV_ZERO_CHK_EN
   localparam bit ZC = 1'b1;
`else
   localparam bit ZC = 1'b0;
`endif
   logic       clk = 1'b0, reset_n = 1'b0, start = 1'b0;
   logic [7:0] dvnd = '0, dvsr = '0;
   logic       ready, done_tick, div0;
   logic [7:0] quo, rmd;
   int         cyc = 0, pass = 0, total = 0, ndone = 0, npush = 0;
   exp_t       sb[$];

   div_seq_para #(.N(8)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .dvnd(dvnd), .dvsr(dvsr),
      .ready(ready), .done_tick(done_tick), .quo(quo), .rmd(rmd), .div0(div0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (reset_n && done_tick) begin
         ndone++;
         if (sb.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            e = sb.pop_front();
            chk("quo", quo, e.q);
            chk("rmd", rmd, e.r);
            chk("div0", div0, e.d);
            chk("latency", cyc, e.c);
         end
      end
   end

   task automatic push(input int q, input int r, input bit d, input int c);
      exp_t e;
      e.q = q[7:0];
      e.r = r[7:0];
      e.d = d;
      e.c = c;
      sb.push_back(e);
      npush++;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ready) chk("ready_timeout", ready, 1);
   endtask

   task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit keep,
                        input int eq, input int er, input bit ed, input int lat);
      wait_ready();
      dvnd  = a;
      dvsr  = b;
      start = 1'b1;
      if (keep) push(eq, er, ed, cyc + lat - 1);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", sb.size(), 0);
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", ready, 1);
      chk("rst_done", done_tick, 0);
      chk("rst_quo", quo, 0);
      chk("rst_rmd", rmd, 0);
      chk("rst_div0", div0, 0);
      reset_n = 1'b1;
      @(negedge clk);
      issue(200, 7, 1, 28, 4, 0, 10);
      issue(255, 1, 1, 255, 0, 0, 10);
      issue(5, 9, 1, 0, 5, 0, 10);
      issue(37, 0, 1, 255, 37, ZC, ZC ? 2 : 10);
      issue(128, 128, 1, 1, 0, 0, 10);
      drain();
      // start pulses mid-division and operand changes must be ignored
      wait_ready();
      dvnd  = 100;
      dvsr  = 3;
      start = 1'b1;
      push(33, 1, 0, cyc + 9);
      for (int j = 2; j <= 11; j++) begin
         @(negedge clk);
         start = (j >= 3 && j <= 6);
         dvnd  = 0;
         dvsr  = 1;
         chk("ready_busy", ready, (j == 11) ? 1 : 0);
      end
      start = 1'b0;
      drain();
      issue(200, 7, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("arst_quo", quo, 0);
      chk("arst_rmd", rmd, 0);
      chk("arst_ready", ready, 1);
      chk("arst_done", done_tick, 0);
      chk("arst_div0", div0, 0);
      @(negedge clk);
      reset_n = 1'b1;
      issue(9, 2, 1, 4, 1, 0, 10);
      drain();
      repeat (12) @(negedge clk);
      wait_ready();
      dvnd  = 50;
      dvsr  = 6;
      start = 1'b1;
      push(8, 2, 0, cyc + 9);
      push(0, 0, 0, cyc + 19);
      push(15, 15, 0, cyc + 29);
      @(negedge clk);
      dvnd = 0;
      dvsr = 5;
      repeat (10) @(negedge clk);
      dvnd = 255;
      dvsr = 16;
      repeat (10) @(negedge clk);
      start = 1'b0;
      drain();
      repeat (12) @(negedge clk);
      chk("done_count", ndone, npush);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule

// File: doc/div_seq_para.md
DIV_SEQ_PARA -- requirements
Module: div_seq_para

Interface
REQ-001 SHALL have parameter N, default 8, operand/result width in bits (N >= 2).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 SHALL have port dvnd  input  N  unsigned dividend; captured on accepted start.
REQ-006 SHALL have port dvsr  input  N  unsigned divisor; captured on accepted start.
REQ-007 SHALL have port ready  output  1  high exactly while in IDLE.
REQ-008 SHALL have port done_tick  output  1  one-cycle pulse; quo/rmd valid that cycle.
REQ-009 SHALL have port quo  output  N  quotient.
REQ-010 SHALL have port rmd  output  N  remainder.
REQ-011 SHALL have port div0  output  1  divide-by-zero flag, valid with done_tick.

Function
REQ-012 SHALL implement a Moore FSM with states IDLE, OP, DONE.
REQ-013 IDLE: start=1 at a clk edge SHALL capture dvnd/dvsr, clear the partial remainder, load a cycle counter with N, go to OP.
REQ-014 OP: each cycle SHALL perform one restoring step: shift {rem, dvnd MSB} left, subtract dvsr in N+1 bits, keep the difference and shift in quotient bit 1 if no borrow, else keep the shifted value and shift in 0; decrement the counter.
REQ-015 OP SHALL last exactly N cycles, then go to DONE.
REQ-016 DONE SHALL assert done_tick for one cycle and return to IDLE.
REQ-017 Latency: done_tick SHALL be high in the (N+2)th cycle counting the start-sampling cycle as cycle 1 (N=8: cycle 10).
REQ-018 quo/rmd SHALL hold their last result from DONE until the next DONE; they SHALL not change at start acceptance.
REQ-019 start while not in IDLE SHALL be ignored; a new start may be accepted in the cycle after DONE.
REQ-020 Divisor 0 SHALL yield quo = all ones, rmd = dvnd (natural restoring-algorithm result).
REQ-021 dvnd < dvsr SHALL yield quo = 0, rmd = dvnd; results SHALL satisfy dvnd = quo*dvsr + rmd, rmd < dvsr for all dvsr != 0.

Reset
REQ-022 reset_n=0 SHALL immediately (asynchronously) force IDLE, quo=0, rmd=0, div0=0, done_tick=0, ready=1, counter=0.
REQ-023 reset mid-OP SHALL abort the operation with no done_tick; the first edge after release SHALL be treated as IDLE.

Configuration
REQ-024 Macro DIV_ZERO_CHK_EN SHALL control divide-by-zero short-circuit.
REQ-025 With DIV_ZERO_CHK_EN defined: start with dvsr=0 SHALL go IDLE->DONE directly (done_tick in cycle 2), quo=all ones, rmd=dvnd, div0=1.
REQ-026 Without DIV_ZERO_CHK_EN: dvsr=0 SHALL run the full N-cycle OP per REQ-020; div0 SHALL be tied to 0.

Structure
REQ-027 Package div_pkg SHALL hold the state enum typedef (IDLE, OP, DONE).
REQ-028 The N+1-bit subtract SHALL be a sub-module sub_borrow_para #(.N) (ports a, b, diff, bout), instantiated with N+1; no other sub-modules.

Verification (N=8)
REQ-029 dvnd=200, dvsr=7, start -> done_tick in cycle 10, quo=28, rmd=4, div0=0.
REQ-030 dvnd=255, dvsr=1 -> quo=255, rmd=0; dvnd=5, dvsr=9 -> quo=0, rmd=5.
REQ-031 dvnd=37, dvsr=0 -> macro on: done_tick cycle 2, quo=255, rmd=37, div0=1; macro off: done_tick cycle 10, same quo/rmd, div0=0.
REQ-032 start pulsed in cycles 3-6 of a 100/3 division -> ignored; one done_tick, quo=33, rmd=1; ready low cycles 2-10.
REQ-033 reset_n low in cycle 5 of a division -> outputs zero immediately, no done_tick, ready=1; following 9/2 gives quo=4, rmd=1.
REQ-034 back-to-back: start held high -> divisions complete every N+2 cycles, each result correct.
